// File: rtl/melody_player_pkg.sv
// Shared types and constants for the melody player sequencer.
package melody_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GAP   = 3'd3,
        ST_END   = 3'd4
    } player_state_t;

    localparam int          NUM_REQ      = 4;
    localparam logic [4:0]  MAX_NOTE_IDX = 5'd31;

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Requesters strictly above the current owner may preempt it.
    function automatic logic [NUM_REQ-1:0] above_mask(input logic [1:0] owner);
        return 4'b1110 << owner;
    endfunction

endpackage

// File: rtl/melody_player_prio_enc4.sv
// 4-bit fixed-priority encoder: bit 3 wins; valid is low when no bit is set.
module prio_enc4 (
    input  logic [3:0] vec,
    output logic [1:0] idx,
    output logic       valid
);

    // Pick the highest set bit.
    always_comb begin
        idx   = 2'd0;
        valid = 1'b1;
        casez (vec)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            4'b0001: idx = 2'd0;
            default: begin
                idx   = 2'd0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: arbitrates sound requests, steps through the melody ROM,
// times each note in beats and gates the tone decoder with a trailing gap.
import melody_pkg::*;

module melody_player #(
    parameter int unsigned BEAT_CYCLES = 32'd12_500_000,
    parameter int unsigned GAP_CYCLES  = 32'd500_000
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0][3:0] reqMelody,
    input  logic                    stop,
    input  logic [3:0]              note_length,
    input  logic                    silenceOutN,
    output logic [3:0]              melodySelect,
    output logic [4:0]              noteIndex,
    output logic                    enableSound,
    output logic                    busy,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    done
);

    localparam int            CW         = $clog2(BEAT_CYCLES);
    localparam logic [CW-1:0] CYC_RELOAD = CW'(BEAT_CYCLES - 32'd1);
    localparam logic [CW-1:0] CYC_GAP    = CW'(GAP_CYCLES);

    player_state_t      state_r;
    logic [1:0]         owner_r;
    logic [CW-1:0]      cyc_cnt_r;
    logic [3:0]         beats_left_r;
    logic [3:0]         melody_sel_r;
    logic [4:0]         note_idx_r;
    logic [NUM_REQ-1:0] grant_r;
    logic               done_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] eligible_s;
    logic [1:0]         win_idx_s;
    logic               win_valid_s;

    // Requests that may be accepted now: all when idle/ending, only higher-priority ones while playing.
    always_comb begin
        eligible_s = 4'b0000;
        case (state_r)
            ST_IDLE, ST_END:           eligible_s = req;
            ST_FETCH, ST_PLAY, ST_GAP: eligible_s = req & above_mask(owner_r);
            default:                   eligible_s = 4'b0000;
        endcase
    end

    prio_enc4 u_prio (
        .vec   (eligible_s),
        .idx   (win_idx_s),
        .valid (win_valid_s)
    );

    // Main sequencer FSM with note timing counters and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= ST_IDLE;
            owner_r      <= 2'd0;
            cyc_cnt_r    <= '0;
            beats_left_r <= 4'd0;
            melody_sel_r <= 4'd0;
            note_idx_r   <= 5'd0;
            grant_r      <= 4'b0000;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            grant_r <= 4'b0000;
            done_r  <= 1'b0;
            if (stop) begin
                // Abort wins over any request; ROM address is held.
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
            end else if (win_valid_s) begin
                state_r      <= ST_FETCH;
                busy_r       <= 1'b1;
                owner_r      <= win_idx_s;
                melody_sel_r <= reqMelody[win_idx_s];
                note_idx_r   <= 5'd0;
                grant_r      <= idx_to_onehot(win_idx_s);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    ST_FETCH: begin
                        busy_r <= 1'b1;
                        if (note_length == 4'd0) begin
                            state_r <= ST_END;
                            done_r  <= 1'b1;
                        end else begin
                            state_r      <= ST_PLAY;
                            beats_left_r <= note_length;
                            cyc_cnt_r    <= CYC_RELOAD;
                        end
                    end
                    ST_PLAY: begin
                        busy_r <= 1'b1;
                        if (cyc_cnt_r == '0) begin
                            cyc_cnt_r    <= CYC_RELOAD;
                            beats_left_r <= beats_left_r - 4'd1;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r - {{(CW-1){1'b0}}, 1'b1};
                        end
                        if ((beats_left_r == 4'd1) && (cyc_cnt_r == CYC_GAP)) begin
                            state_r <= ST_GAP;
                        end else begin
                            state_r <= ST_PLAY;
                        end
                    end
                    ST_GAP: begin
                        busy_r <= 1'b1;
                        if (cyc_cnt_r == '0) begin
                            if (note_idx_r == MAX_NOTE_IDX) begin
                                state_r <= ST_END;
                                done_r  <= 1'b1;
                            end else begin
                                state_r    <= ST_FETCH;
                                note_idx_r <= note_idx_r + 5'd1;
                            end
                        end else begin
                            state_r   <= ST_GAP;
                            cyc_cnt_r <= cyc_cnt_r - {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_END: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign melodySelect = melody_sel_r;
    assign noteIndex    = note_idx_r;
    assign grant        = grant_r;
    assign done         = done_r;
    assign busy         = busy_r;
    // Rests keep their timing but never open the tone gate.
    assign enableSound  = (state_r == ST_PLAY) && silenceOutN;

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player with a small jukebox ROM model.
module tb_melody_player;

    logic            clk = 1'b0;
    logic            resetN;
    logic [3:0]      req;
    logic [3:0][3:0] reqMelody;
    logic            stop;
    logic [3:0]      note_length;
    logic            silenceOutN;
    logic [3:0]      melodySelect;
    logic [4:0]      noteIndex;
    logic            enableSound;
    logic            busy;
    logic [3:0]      grant;
    logic            done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       is_done;
        logic [3:0] gnt;
        logic [3:0] mel;
        logic [4:0] idx;
    } exp_t;
    exp_t sb_q[$];

    melody_player #(.BEAT_CYCLES(10), .GAP_CYCLES(2)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .req          (req),
        .reqMelody    (reqMelody),
        .stop         (stop),
        .note_length  (note_length),
        .silenceOutN  (silenceOutN),
        .melodySelect (melodySelect),
        .noteIndex    (noteIndex),
        .enableSound  (enableSound),
        .busy         (busy),
        .grant        (grant),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Jukebox ROM model: 4 = one note L=2; 5 = rest L=3, note L=1; 6 = 32 x L=1;
    // 7 = long notes L=15; 9 = one note L=2. Anything else reads as terminator.
    always_comb begin
        note_length = 4'd0;
        silenceOutN = 1'b1;
        case (melodySelect)
            4'd4: note_length = (noteIndex == 5'd0) ? 4'd2 : 4'd0;
            4'd5: begin
                note_length = (noteIndex == 5'd0) ? 4'd3 : ((noteIndex == 5'd1) ? 4'd1 : 4'd0);
                silenceOutN = (noteIndex == 5'd0) ? 1'b0 : 1'b1;
            end
            4'd6: note_length = 4'd1;
            4'd7: note_length = 4'd15;
            4'd9: note_length = (noteIndex == 5'd0) ? 4'd2 : 4'd0;
            default: note_length = 4'd0;
        endcase
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic [3:0] g, input logic [3:0] m);
        exp_t e;
        e.is_done = 1'b0; e.gnt = g; e.mel = m; e.idx = 5'd0;
        sb_q.push_back(e);
    endtask

    task automatic push_done(input logic [3:0] m, input logic [4:0] i);
        exp_t e;
        e.is_done = 1'b1; e.gnt = 4'b0000; e.mel = m; e.idx = i;
        sb_q.push_back(e);
    endtask

    // Issue a one-cycle request vector.
    task automatic pulse_req(input logic [3:0] r);
        req = r;
        tick();
        req = 4'b0000;
    endtask

    // Wait for the player to go idle, bounded.
    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            n++;
            tick();
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    // Monitor: pop and compare whenever the DUT shows a grant or done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (resetN && (grant != 4'b0000 || done)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: grant=%b done=%b, expected none", grant, done);
            end else begin
                e = sb_q.pop_front();
                check(e.is_done ? "done_pulse" : "grant_pulse", int'(done), int'(e.is_done));
                check("grant_vec", int'(grant), int'(e.gnt));
                check("event_melody", int'(melodySelect), int'(e.mel));
                check("event_index", int'(noteIndex), int'(e.idx));
            end
        end
    end

    initial begin
        int n, hi, lo;
        logic [4:0] prev_idx, max_idx;
        logic wrapped;

        resetN = 1'b0;
        req = 4'b0000;
        stop = 1'b0;
        reqMelody = '0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_sel", int'(melodySelect), 0);
        check("rst_idx", int'(noteIndex), 0);
        check("rst_en", int'(enableSound), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_done", int'(done), 0);
        resetN = 1'b1;
        tick();

        // Single note: L=2 -> 18 sounding cycles, then GAP(2)+FETCH+END silent.
        reqMelody[0] = 4'd4;
        push_grant(4'b0001, 4'd4);
        push_done(4'd4, 5'd1);
        pulse_req(4'b0001);
        check("single_fetch_en", int'(enableSound), 0);
        check("single_fetch_busy", int'(busy), 1);
        tick();
        hi = 0;
        while (enableSound && hi < 100) begin hi++; tick(); end
        check("single_hi_cycles", hi, 18);
        lo = 0;
        while (!enableSound && busy && lo < 100) begin lo++; tick(); end
        check("single_tail_cycles", lo, 4);
        check("single_busy_fall", int'(busy), 0);
        tick();

        // Rest note: silent for 31 cycles FETCH-to-FETCH, then an 8-cycle tone.
        reqMelody[1] = 4'd5;
        push_grant(4'b0010, 4'd5);
        push_done(4'd5, 5'd2);
        pulse_req(4'b0010);
        n = 0; hi = 0;
        while (noteIndex != 5'd1 && n < 100) begin
            if (enableSound) hi++;
            n++;
            tick();
        end
        check("rest_fetch_spacing", n, 31);
        check("rest_silent", hi, 0);
        hi = 0; n = 0;
        while (busy && n < 100) begin
            if (enableSound) hi++;
            n++;
            tick();
        end
        check("rest_next_hi", hi, 8);
        tick();

        // Preemption by requester 2, then a lower request that must be dropped.
        reqMelody[0] = 4'd7;
        reqMelody[2] = 4'd9;
        push_grant(4'b0001, 4'd7);
        pulse_req(4'b0001);
        repeat (5) tick();
        check("pre_playing", int'(enableSound), 1);
        push_grant(4'b0100, 4'd9);
        push_done(4'd9, 5'd1);
        pulse_req(4'b0100);
        check("pre_sel", int'(melodySelect), 9);
        check("pre_idx", int'(noteIndex), 0);
        repeat (3) tick();
        pulse_req(4'b0010);
        check("pre_low_no_grant", int'(grant), 0);
        check("pre_low_sel", int'(melodySelect), 9);
        wait_idle(200);
        tick();

        // Stop mid-PLAY together with a top-priority request.
        push_grant(4'b0001, 4'd7);
        pulse_req(4'b0001);
        repeat (6) tick();
        check("stop_pre_en", int'(enableSound), 1);
        stop = 1'b1;
        req = 4'b1000;
        tick();
        stop = 1'b0;
        req = 4'b0000;
        check("stop_busy", int'(busy), 0);
        check("stop_en", int'(enableSound), 0);
        check("stop_grant", int'(grant), 0);
        check("stop_done", int'(done), 0);
        check("stop_sel_hold", int'(melodySelect), 7);
        repeat (3) tick();
        check("stop_still_idle", int'(busy), 0);

        // Full-length melody: 32 notes of L=1, no terminator.
        reqMelody[3] = 4'd6;
        push_grant(4'b1000, 4'd6);
        push_done(4'd6, 5'd31);
        pulse_req(4'b1000);
        n = 0; wrapped = 1'b0; max_idx = 5'd0; prev_idx = noteIndex;
        while (busy && n < 1000) begin
            if (noteIndex == 5'd0 && prev_idx != 5'd0) wrapped = 1'b1;
            if (noteIndex > max_idx) max_idx = noteIndex;
            prev_idx = noteIndex;
            n++;
            tick();
        end
        check("full_busy_cycles", n, 353);
        check("full_no_wrap", int'(wrapped), 0);
        check("full_max_idx", int'(max_idx), 31);
        tick();

        // Asynchronous reset during GAP.
        push_grant(4'b0001, 4'd4);
        reqMelody[0] = 4'd4;
        pulse_req(4'b0001);
        n = 0;
        while (!enableSound && n < 50) begin n++; tick(); end
        while (enableSound && n < 100) begin n++; tick(); end
        check("areset_in_gap", int'(busy), 1);
        #2;
        resetN = 1'b0;
        #1;
        check("areset_busy", int'(busy), 0);
        check("areset_en", int'(enableSound), 0);
        check("areset_sel", int'(melodySelect), 0);
        check("areset_idx", int'(noteIndex), 0);
        check("areset_grant", int'(grant), 0);
        check("areset_done", int'(done), 0);
        tick();
        resetN = 1'b1;
        tick();
        push_grant(4'b0001, 4'd4);
        push_done(4'd4, 5'd1);
        pulse_req(4'b0001);
        check("after_reset_idx", int'(noteIndex), 0);
        check("after_reset_sel", int'(melodySelect), 4);
        wait_idle(100);
        repeat (2) tick();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/melody_player.md
# melody_player

Sequencer between game-event sound requests and the jukebox melody ROM. It arbitrates up to four requesters by fixed priority and drives `melodySelect`/`noteIndex` into the ROM. It times each note from the ROM's `note_length` in beats and gates the tone decoder with `enableSound`, inserting a short silent gap at the end of every note.

## Interface
- `BEAT_CYCLES`, 12_500_000: clk cycles per beat (0.25 s at 50 MHz); must be ≥ 2.
- `GAP_CYCLES`, 500_000: silent cycles at the end of each note; 1 ≤ `GAP_CYCLES` < `BEAT_CYCLES`.
- `clk` in 1: system clock; the block has one clock.
- `resetN` in 1: asynchronous, active-low reset.
- `req` in 4: play-request pulses; bit 3 has the highest priority.
- `reqMelody` in 4×4 (packed [3:0][3:0]): melody id for each requester.
- `stop` in 1: abort playback.
- `note_length` in 4: beats for the current note, from the ROM; 0 marks end of melody.
- `silenceOutN` in 1: from the ROM; 0 means a rest note.
- `melodySelect` out 4: registered melody id driven to the ROM.
- `noteIndex` out 5: registered note index driven to the ROM.
- `enableSound` out 1: tone gate.
- `busy` out 1: high in every state except IDLE.
- `grant` out 4: one-hot, one-cycle pulse when a request is accepted.
- `done` out 1: one-cycle pulse on natural end of melody.

## Operation
- States:
  - IDLE
  - FETCH (1 cycle; ROM outputs settle and are sampled)
  - PLAY
  - GAP
  - END
- **Accept (IDLE or END):** any `req` bit set selects the winner w = highest set bit.
  - Registered next cycle: `melodySelect`=`reqMelody[w]`, `noteIndex`=0, owner=w.
  - `grant[w]` pulses; next state FETCH.
- **Preempt (FETCH/PLAY/GAP):** a `req` bit with index > owner is accepted the same way and restarts at FETCH.
  - Requests with index ≤ owner are dropped, not queued.
- **FETCH:**
  - `note_length`=0: go to END.
  - Otherwise load beatsLeft=`note_length` and cycCnt=`BEAT_CYCLES`-1; go to PLAY.
- **PLAY:** each cycle, if cycCnt=0 then cycCnt←`BEAT_CYCLES`-1 and beatsLeft−1; else cycCnt−1.
  - When beatsLeft=1 and cycCnt=`GAP_CYCLES`, go to GAP (cycCnt keeps decrementing).
- **GAP:** leave when cycCnt=0.
  - If `noteIndex`=31, go to END (wrap is never taken).
  - Else `noteIndex`+1 and go to FETCH.
- **END:** `done` pulses for this one cycle, then IDLE. A request in END is accepted (`done` still pulses).
- **stop:** from any state, next state IDLE with no `done`; `melodySelect`/`noteIndex` hold their values.
  - `stop` together with `req`: `stop` wins and the request is dropped.
- **enableSound** = (state=PLAY) && `silenceOutN`, combinational from the registered state and the ROM output. Rests keep timing but stay silent.

## Timing
- Reset values: state IDLE; `melodySelect`=0, `noteIndex`=0, `grant`=0, `done`=0, `busy`=0, `enableSound`=0; counters 0.
- Request at edge k: `grant` is high during cycle k+1 (state FETCH); PLAY begins at k+2.
- Per note of length L: 1 FETCH cycle + L·`BEAT_CYCLES` cycles, of which `enableSound` is high for L·`BEAT_CYCLES`−`GAP_CYCLES`.
- End of melody: END follows the FETCH that reads length 0; `done` pulses 1 cycle after that FETCH.
- Reset mid-note forces IDLE immediately (asynchronous); `enableSound` drops without waiting for a clock edge.

## Structure
- `melody_pkg` holds:
  - state enum `player_state_t`
  - `NUM_REQ`=4
  - `MAX_NOTE_IDX`=5'd31
- One sub-module is natural: `prio_enc4`, a 4-bit priority encoder returning winner index and a valid flag.
  - It is used for both accept and preempt compares.
- Counters stay inline; cycCnt width is $clog2(`BEAT_CYCLES`), beatsLeft is 4 bits.

## Test plan
Bench uses a jukebox ROM model with `BEAT_CYCLES`=10, `GAP_CYCLES`=2.
- **Single note:** `req`=4'b0001, `reqMelody[0]`=4 (one note, L=2, then terminator) -> `grant`=0001 at k+1; `enableSound` high for 18 cycles, then 2 low; `done` pulses once; `busy` falls.
- **Rest timing:** melody with a silence note of L=3 -> `enableSound` stays 0 for that note; the next note's FETCH comes 31 cycles after the rest's FETCH.
- **Preemption:** owner 0 playing, `req`=4'b0100 -> `grant`=0100, `noteIndex`→0, `melodySelect`=`reqMelody[2]`; a subsequent `req`=4'b0010 is ignored (no `grant`).
- **Stop:** `stop` mid-PLAY, also with simultaneous `req`=4'b1000 -> IDLE next cycle; `enableSound`=0, no `done`, no `grant`.
- **Full-length melody:** 32 notes with no terminator -> after `noteIndex`=31 GAP, END with `done`; `noteIndex` never wraps to 0 during play.
- **Async reset:** assert `resetN`=0 during GAP -> all outputs at reset values without a clock edge; the first `req` after release plays from note 0.
